// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B engine, one full-subtractor bit per clock.
//
// The operands are loaded in parallel and processed LSB first. The borrow is
// held in a register between bits. The result is given both as a serial stream
// (d_bit/d_valid) and as a parallel word (diff/borrow_out).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             load request, honoured only while busy==0
//   a_in, b_in        minuend / subtrahend, sampled with an accepted start
//   busy              operation in progress (WIDTH cycles)
//   done              one-cycle pulse; diff/borrow_out (and ovf) are valid
//   d_bit, d_valid    serial difference bit, LSB first, and its qualifier
//   diff              a_in-b_in mod 2^WIDTH, held until the next accepted start
//   borrow_out        final borrow (a_in < b_in, unsigned)
//   ovf               signed overflow; present only when SERIAL_SUB_OVF_EN is defined
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf port and its logic.

// Combinational full-subtractor cell. It is the mirror of a full adder cell.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             d_bit,
  output logic             d_valid,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic            load, last;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic            bor, bor_nxt, d;
  logic [CW-1:0]   count;
`ifdef SERIAL_SUB_OVF_EN
  logic            a_msb, b_msb;
`endif

  // The cell always looks at bit 0. The operand registers shift right, so
  // bit 0 of each register holds bit 'count' of the latched operand.
  fs_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bor),
    .d    (d),
    .bout (bor_nxt)
  );

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (count == CW'(WIDTH - 1)) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      bor        <= 1'b0;
      count      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      done       <= 1'b0;
      d_bit      <= 1'b0;
      d_valid    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      d_valid <= 1'b0;
      if (load) begin
        a_sh       <= a_in;
        b_sh       <= b_in;
        bor        <= 1'b0;
        count      <= '0;
        diff       <= '0;
        borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb      <= a_in[WIDTH-1];
        b_msb      <= b_in[WIDTH-1];
        ovf        <= 1'b0;
`endif
      end else if (busy) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        bor     <= bor_nxt;
        count   <= count + CW'(1);
        // The difference enters at the MSB end, so after WIDTH shifts bit 0
        // is where it belongs.
        diff    <= {d, diff[WIDTH-1:1]};
        d_bit   <= d;
        d_valid <= 1'b1;
        if (last) begin
          borrow_out <= bor_nxt;
          done       <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit, d becomes diff[WIDTH-1].
          ovf        <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         busy, done, d_bit, d_valid, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .d_bit      (d_bit),
    .d_valid    (d_valid),
    .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf),
`endif
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle or in its done cycle. Drives start,
  // follows the run, and returns at the negedge where done is seen.
  // busy_start_at >= 1 pulses start (with a_in=AA) during that busy cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_diff, input logic exp_bor,
                        input logic exp_ovf, input int busy_start_at);
    logic [W-1:0] stream;
    int nbusy, nvalid, done_at;
    stream = '0; nbusy = 0; nvalid = 0; done_at = -1;
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Checked just after the start-capture edge.
    chk({tag, " busy@start"}, 32'(busy), 32'd1);
    chk({tag, " diff_clr"}, 32'(diff), 32'd0);
    chk({tag, " done_low"}, 32'(done), 32'd0);
    if (busy) nbusy++;
    for (int i = 1; i <= 20 && done_at < 0; i++) begin
      if (i == busy_start_at) begin
        start = 1'b1; a_in = 8'hAA; b_in = 8'h00;
      end
      @(negedge clk);
      start = 1'b0;
      if (d_valid) begin
        stream = {d_bit, stream[W-1:1]};
        nvalid++;
      end
      if (busy) nbusy++;
      if (done) done_at = i;
    end
    chk({tag, " done_latency"}, 32'(done_at), 32'd8);
    chk({tag, " diff"}, 32'(diff), 32'(exp_diff));
    chk({tag, " borrow"}, 32'(borrow_out), 32'(exp_bor));
    chk({tag, " stream"}, 32'(stream), 32'(exp_diff));
    chk({tag, " dvalid_cnt"}, 32'(nvalid), 32'd8);
    chk({tag, " busy_cnt"}, 32'(nbusy), 32'd8);
    chk({tag, " dvalid_at_done"}, 32'(d_valid), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) ; // ovf is not checked without the port
`endif
  endtask

  initial begin
    int ndone;
    // Reset state
    #2;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst dvalid", 32'(d_valid), 32'd0);
    chk("rst diff", 32'(diff), 32'd0);
    chk("rst borrow", 32'(borrow_out), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("5-3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, -1);
    // Hold after done: the done pulse lasts one cycle and the result stays.
    @(negedge clk);
    chk("hold done", 32'(done), 32'd0);
    chk("hold dvalid", 32'(d_valid), 32'd0);
    chk("hold busy", 32'(busy), 32'd0);
    chk("hold diff", 32'(diff), 32'h02);
    run_op("3-5", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, -1);
    // Back-to-back: each of these starts in the done cycle of the previous op.
    run_op("00-00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, -1);
    run_op("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, -1);
    run_op("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, -1);
    run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, -1);
    run_op("7F-01", 8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0, -1);
    // A start during busy (with new operands) must be ignored.
    run_op("busy_start", 8'h12, 8'h34, 8'hDE, 1'b1, 1'b0, 3);
    @(negedge clk);
    chk("no_restart busy", 32'(busy), 32'd0);

    // Reset in the middle of an operation.
    a_in = 8'h55; b_in = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst dvalid", 32'(d_valid), 32'd0);
    chk("midrst dbit", 32'(d_bit), 32'd0);
    chk("midrst diff", 32'(diff), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midrst no_done", 32'(ndone), 32'd0);
    run_op("after_rst", 8'h55, 8'h0F, 8'h46, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
